datamem_arbiter: RTL and testbench
==================================

Name: datamem_arbiter

Overview:
- Sequences and shares the single datamem instance (address, write-data, enable, readwrite, dataOut) between two requesters.
- Port 0 is the CPU load/store path; port 1 is the debug/program loader.
- Accepts one transaction at a time over valid/ready, drives the memory control signals for exactly one cycle, and returns read data or write acknowledgement with a one-cycle response pulse.
- Sits between the core/loader and datamem at the top level.

Parameters:
- ADDR_W, 16, implemented word-address bits (datamem depth = 2^ADDR_W = 65536)
- MEM_LAT, 1, cycles from mem_enable sample edge to valid mem_rdata (legal 1..4)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 / port 1
- req0_ready / req1_ready  out  1  arbiter accepts the request this cycle
- req0_we / req1_we  in  1  1 = store, 0 = load
- req0_addr / req1_addr  in  32  word address
- req0_wdata / req1_wdata  in  32  store data
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_rdata / rsp1_rdata  out  32  load data; 0 for stores and errors
- rsp0_err / rsp1_err  out  1  address out of range, valid with rsp pulse
- mem_addr  out  32  to datamem address input
- mem_wdata  out  32  to datamem write-data input
- mem_enable  out  1  to datamem enable
- mem_readwrite  out  1  to datamem readwrite (1 = write)
- mem_rdata  in  32  from datamem dataOut
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst = 0, asynchronous):
  - State returns to IDLE and the round-robin pointer is set to 0 (port 0 preferred).
  - Every output goes to 0, including an in-flight transaction, which is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req*_ready is combinational and asserted only for the arbitration winner among valid ports.
  - Both valid: the pointer port wins; the pointer then moves to the other port on accept.
  - Single valid: that port wins, and the pointer still toggles to the non-granted port.
  - Handshake occurs when valid && ready; at that edge, latch id, we, addr and wdata, then go to ISSUE.
- ISSUE (1 cycle):
  - If addr[31:ADDR_W] != 0: mem_enable stays 0, the error flag is set, and the state goes to RESP.
  - Otherwise: mem_enable = 1, mem_readwrite = we, mem_addr = addr, mem_wdata = wdata. Go to WAIT when MEM_LAT > 1, else to RESP.
- WAIT: a down-counter holds the state for MEM_LAT-1 cycles; mem_enable = 0 and mem_addr/mem_wdata are held.
- RESP (1 cycle):
  - rspN_valid = 1 for the latched id only.
  - Load: rdata = mem_rdata sampled at this edge.
  - Store: rdata = 0.
  - Error: rdata = 0, err = 1.
  - Next state is IDLE.
- Outside RESP, rsp*_valid = 0 and rsp*_rdata/err are held at their last values.
- Outside ISSUE, mem_enable = 0.
- Throughput: one transaction per MEM_LAT + 2 cycles. Ready is never asserted outside IDLE.
- Request latency: accept edge to rsp pulse is MEM_LAT + 1 cycles.
- Requester rules:
  - A requester may drop valid before ready with no effect.
  - Request fields must be stable only at the accept edge.
- No write is ever issued without a handshake, and no duplicate response is ever generated.

Decomposition:
- Package datamem_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - PORT_CPU = 0, PORT_DBG = 1
  - RW_READ = 0, RW_WRITE = 1
  - DATA_W = 32
- Sub-module rr_arbiter2: 2-input round-robin grant with pointer update on accept. It is instantiated once.

Test Plan:
- Reset then port0 load addr 1 -> mem_enable for one cycle with mem_readwrite = 0 and mem_addr = 1; rsp0_valid pulses MEM_LAT+1 cycles after accept; rsp0_rdata = 0 from the zeroed memory.
- Port0 store addr 1 data 32'hFFFFFFFF, then load addr 1 -> store rsp0_valid with rdata 0; load rsp0_rdata = 32'hFFFFFFFF.
- Both ports valid continuously with loads from addr 2 and 3 -> grants alternate 0,1,0,1; each port sees a response every 2*(MEM_LAT+2) cycles; no starvation.
- Port1 load addr 32'h0001_0000 -> mem_enable never asserted; rsp1_valid with rsp1_err = 1 and rdata 0.
- rst driven low during WAIT (MEM_LAT = 3), then released -> outputs 0 immediately, no rsp pulse, next request served normally from IDLE with port 0 priority.
- Port0 valid raised and dropped while busy -> no extra memory access and no response; busy stays high only for the active transaction.

Source files
------------

// File: rtl/datamem_pkg.sv
// Shared types and constants for the datamem arbiter: FSM states, port ids,
// readwrite encoding and the latched request record.
package datamem_pkg;
  localparam int DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // True when any bit above the implemented word-address range is set.
  function automatic logic addr_oor(input logic [DATA_W-1:0] addr, input int addr_w);
    return (addr >> addr_w) != '0;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. The pointer names the preferred port and
// moves to the port that was not granted whenever a grant is accepted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic ptr;

  always_comb begin
    grant = valid;
    if (&valid) grant = ptr ? 2'b10 : 2'b01;
  end

  // grant[0] set means port 0 won, so port 1 becomes preferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ptr <= 1'b0;
    else if (accept) ptr <= grant[0];
  end
endmodule

// File: rtl/datamem_arbiter.sv
// Shares one datamem between the CPU load/store port and the debug loader:
// one transaction at a time, one-cycle memory strobe, one-cycle response pulse.
module datamem_arbiter
  import datamem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [DATA_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [DATA_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_enable,
  output logic              mem_readwrite,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t                   state, state_nxt;
  req_t [1:0]               req_in;
  req_t                     cur;
  logic                     cur_id;
  logic [2:0]               cnt;
  logic [1:0]               req_valid, grant, ready;
  logic                     idle, accept, oor;
  logic [1:0]               rsp_valid;
  logic [1:0][DATA_W-1:0]   rsp_rdata;
  logic [1:0]               rsp_err;

  assign req_valid = {req1_valid, req0_valid};
  assign req_in[PORT_CPU] = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
  assign req_in[PORT_DBG] = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};

  assign idle   = (state == IDLE);
  assign accept = idle && rst && (|grant);
  assign oor    = addr_oor(cur.addr, ADDR_W);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Ready is gated by reset so every output reads 0 while rst is low.
  assign ready      = {2{idle && rst}} & grant;
  assign req0_ready = ready[PORT_CPU];
  assign req1_ready = ready[PORT_DBG];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = (oor || MEM_LAT <= 1) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur       <= '0;
      cur_id    <= PORT_CPU;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= '0;
      if (accept) begin
        cur    <= req_in[grant[PORT_DBG]];
        cur_id <= grant[PORT_DBG];
      end
      // WAIT lasts MEM_LAT-1 cycles: preload MEM_LAT-2 and exit on zero.
      if (state == ISSUE)     cnt <= 3'(MEM_LAT - 2);
      else if (state == WAIT) cnt <= cnt - 3'd1;
      if (state == RESP) begin
        rsp_valid[cur_id] <= 1'b1;
        rsp_rdata[cur_id] <= (cur.we || oor) ? '0 : mem_rdata;
        rsp_err[cur_id]   <= oor;
      end
    end
  end

  // Address/data stay on the latched request, so they hold through WAIT.
  assign mem_enable    = (state == ISSUE) && !oor;
  assign mem_readwrite = mem_enable && (cur.we == RW_WRITE);
  assign mem_addr      = cur.addr;
  assign mem_wdata     = cur.wdata;
  assign busy          = !idle;

  assign rsp0_valid = rsp_valid[PORT_CPU];
  assign rsp1_valid = rsp_valid[PORT_DBG];
  assign rsp0_rdata = rsp_rdata[PORT_CPU];
  assign rsp1_rdata = rsp_rdata[PORT_DBG];
  assign rsp0_err   = rsp_err[PORT_CPU];
  assign rsp1_err   = rsp_err[PORT_DBG];

  a_ready_idle: assert property (@(posedge clk) disable iff (!rst) !idle |-> ready == 2'b00);
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(rsp_valid));
endmodule

// File: tb/tb_datamem_arbiter.sv
// Randomized and directed bench for datamem_arbiter: a transaction-level model
// predicts every output each cycle; a simple latency-MEM_LAT memory stands in for datamem.
module tb_datamem_arbiter;
  localparam int ADDR_W  = 16;
  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_enable, mem_readwrite, busy;

  int vectors = 0;
  int miscompares = 0;

  datamem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_enable(mem_enable),
    .mem_readwrite(mem_readwrite), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // datamem stand-in: zeroed, writes on enable, read data after MEM_LAT edges.
  logic [31:0] emem [0:65535];
  logic [31:0] rd_pipe [MEM_LAT];
  assign mem_rdata = rd_pipe[MEM_LAT-1];
  initial begin
    for (int i = 0; i < 65536; i++) emem[i] = '0;
    for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
    forever begin
      @(posedge clk);
      if (mem_enable && mem_readwrite) emem[mem_addr[15:0]] <= mem_wdata;
      if (mem_enable && !mem_readwrite) rd_pipe[0] <= emem[mem_addr[15:0]];
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------------
  logic [31:0] ref_mem [int unsigned];
  int          m_age;           // 0 idle, k = edges since accept
  bit          m_ptr, m_id, m_we;
  logic [31:0] m_addr, m_wdata;
  bit          e_rv [2];
  logic [31:0] e_rd [2];
  bit          e_err [2];

  function automatic bit out_of_range(input logic [31:0] a);
    return longint'(a) >= (longint'(1) << ADDR_W);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  initial begin
    bit any, win, e_en, m_oor;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_age = 0; m_ptr = 0; m_id = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        for (int p = 0; p < 2; p++) begin e_rv[p] = 0; e_rd[p] = '0; e_err[p] = 0; end
      end
      any   = req0_valid || req1_valid;
      win   = (req0_valid && req1_valid) ? m_ptr : !req0_valid;
      m_oor = out_of_range(m_addr);
      e_en  = (m_age == 1) && !m_oor;
      chk1("req0_ready", req0_ready, rst && m_age == 0 && any && win == 0);
      chk1("req1_ready", req1_ready, rst && m_age == 0 && any && win == 1);
      chk1("busy", busy, m_age != 0);
      chk1("mem_enable", mem_enable, e_en);
      chk1("mem_readwrite", mem_readwrite, e_en && m_we);
      if (e_en || !rst) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk1("rsp0_valid", rsp0_valid, e_rv[0]);
      chk1("rsp1_valid", rsp1_valid, e_rv[1]);
      chk("rsp0_rdata", rsp0_rdata, e_rd[0]);
      chk("rsp1_rdata", rsp1_rdata, e_rd[1]);
      chk1("rsp0_err", rsp0_err, e_err[0]);
      chk1("rsp1_err", rsp1_err, e_err[1]);
      if (rst) begin
        e_rv[0] = 0; e_rv[1] = 0;
        if (m_age == 0) begin
          if (any) begin
            m_id    = win;
            m_we    = win ? req1_we    : req0_we;
            m_addr  = win ? req1_addr  : req0_addr;
            m_wdata = win ? req1_wdata : req0_wdata;
            m_ptr   = !win;
            m_age   = 1;
          end
        end else if (m_age == MEM_LAT + 1) begin
          e_rv[m_id]  = 1;
          e_err[m_id] = m_oor;
          e_rd[m_id]  = (m_oor || m_we) ? 32'h0 : ref_read(m_addr);
          if (!m_oor && m_we) ref_mem[m_addr] = m_wdata;
          m_age = 0;
        end else if (m_age == 1 && m_oor) m_age = MEM_LAT + 1;
        else m_age++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit port, input bit v, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata; end
    else      begin req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata; end
  endtask

  // Single-port transaction; lat = accept edge to response pulse, nen = strobes seen.
  task automatic xact(input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output bit err, output int lat, output int nen);
    bit acc = 0, got = 0;
    int n = 0;
    rdata = '0; err = 0; lat = -1; nen = 0;
    set_req(port, 1, we, addr, wdata);
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = port ? req1_ready : req0_ready;
      step();
    end
    set_req(port, 0, 0, '0, '0);
    if (!acc) begin chk1("accept_timeout", 1'b0, 1'b1); return; end
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_enable) nen++;
      if (port ? rsp1_valid : rsp0_valid) begin
        got = 1; lat = n - 1;
        rdata = port ? rsp1_rdata : rsp0_rdata;
        err   = port ? rsp1_err   : rsp0_err;
      end
    end
    if (!got) chk1("response_timeout", 1'b0, 1'b1);
    step();
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = !busy;
      step();
    end
    chk1("idle_timeout", ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit er, acc;
    int lat, nen, last0, last1, nbusy, np0, np1;
    bit g[$];

    // reset state with a request pending
    req0_valid = 1;
    @(negedge clk);
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_enable", mem_enable, 1'b0);
    step();
    req0_valid = 0;
    rst = 1;
    step();

    // load from zeroed memory, store, load back
    xact(0, 0, 32'd1, '0, rd, er, lat, nen);
    chk("ld1_rdata", rd, 32'h0);
    chk("ld1_lat", 32'(lat), 32'(MEM_LAT + 1));
    chk("ld1_strobes", 32'(nen), 32'd1);
    xact(0, 1, 32'd1, 32'hFFFF_FFFF, rd, er, lat, nen);
    chk("st1_rdata", rd, 32'h0);
    xact(0, 0, 32'd1, '0, rd, er, lat, nen);
    chk("ld1b_rdata", rd, 32'hFFFF_FFFF);

    // both ports loading continuously must alternate
    xact(1, 1, 32'd2, 32'h1234_5678, rd, er, lat, nen);
    xact(0, 1, 32'd3, 32'hCAFE_F00D, rd, er, lat, nen);
    set_req(0, 1, 0, 32'd2, '0);
    set_req(1, 1, 0, 32'd3, '0);
    last0 = -1; last1 = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
      if (rsp0_valid) begin
        chk("rr_rsp0_data", rsp0_rdata, 32'h1234_5678);
        if (last0 >= 0) chk("rr_rsp0_gap", 32'(c - last0), 32'(2 * (MEM_LAT + 2)));
        last0 = c;
      end
      if (rsp1_valid) begin
        chk("rr_rsp1_data", rsp1_rdata, 32'hCAFE_F00D);
        if (last1 >= 0) chk("rr_rsp1_gap", 32'(c - last1), 32'(2 * (MEM_LAT + 2)));
        last1 = c;
      end
      step();
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    chk1("rr_grant_count", g.size() >= 11, 1'b1);
    for (int i = 1; i < g.size(); i++) chk1("rr_alternate", g[i], !g[i-1]);
    wait_idle();

    // out-of-range address: error, no strobe, skips the memory wait
    xact(1, 0, 32'h0001_0000, '0, rd, er, lat, nen);
    chk1("oor_err", er, 1'b1);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_strobes", 32'(nen), 32'd0);
    chk("oor_lat", 32'(lat), 32'd2);

    // reset in WAIT drops the transaction; port 0 preferred afterwards
    set_req(1, 1, 0, 32'd2, '0);
    acc = 0;
    for (int t = 0; t < 20 && !acc; t++) begin @(negedge clk); acc = req1_ready; step(); end
    set_req(1, 0, 0, '0, '0);
    chk1("rw_accept", acc, 1'b1);
    step();
    chk1("rw_busy_wait", busy, 1'b1);
    rst = 0;
    #1;
    chk1("rw_busy_rst", busy, 1'b0);
    chk1("rw_rsp1_rst", rsp1_valid, 1'b0);
    step(); step();
    rst = 1;
    np1 = 0;
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (rsp1_valid) np1++; step(); end
    chk("rw_no_rsp", 32'(np1), 32'd0);
    set_req(0, 1, 0, 32'd3, '0);
    set_req(1, 1, 0, 32'd2, '0);
    @(negedge clk);
    chk1("rw_prio0", req0_ready, 1'b1);
    chk1("rw_prio1", req1_ready, 1'b0);
    step();
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    wait_idle();

    // port 0 pulses valid while busy: no access, no response
    set_req(1, 1, 1, 32'd5, 32'h55);
    acc = 0;
    for (int t = 0; t < 20 && !acc; t++) begin @(negedge clk); acc = req1_ready; step(); end
    set_req(1, 0, 0, '0, '0);
    chk1("dv_accept", acc, 1'b1);
    nbusy = 0; nen = 0; np0 = 0; np1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (mem_enable) nen++;
      if (rsp0_valid) np0++;
      if (rsp1_valid) np1++;
      step();
      if (c == 0) set_req(0, 1, 1, 32'd6, 32'h66);
      if (c == 1) set_req(0, 0, 0, '0, '0);
    end
    chk("dv_busy_cycles", 32'(nbusy), 32'(MEM_LAT + 1));
    chk("dv_strobes", 32'(nen), 32'd1);
    chk("dv_rsp0", 32'(np0), 32'd0);
    chk("dv_rsp1", 32'(np1), 32'd1);

    // random traffic, fields churn freely while not accepted
    for (int c = 0; c < 2500; c++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a;
        a = ($urandom_range(0, 99) < 88) ? 32'($urandom_range(0, 15))
                                         : ($urandom | 32'h0001_0000);
        set_req(p[0], $urandom_range(0, 99) < 45, 1'($urandom_range(0, 1)), a, $urandom);
      end
      if ($urandom_range(0, 999) == 0) begin rst = 0; step(); rst = 1; end
      step();
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
